// File: rtl/fetch_redirect_unit.sv
// Fetch PC register and IF/ID register with jump/branch redirect and stall.
// In: clk, reset, Stall, redirect reqs/targets, Instruction. Out: PC, IF/ID, Flush, count.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        ORForBranch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        JumpRegister,
  input  logic [31:0] JRTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Flush,
  output logic [15:0] RedirectCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] p4_q, p4_d;
  logic        vld_q, vld_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic        redir;

  assign pc_plus4 = pc_q + 32'd4;
  assign redir    = JumpRegister | Jump | ORForBranch;

  // Reset is sampled synchronously, so Flush is masked here as well.
  assign Flush = reset & ~Stall & redir;

  always_comb begin
    tgt = BranchTarget;
    if (JumpRegister) begin
      tgt = JRTarget;
    end else if (Jump) begin
      tgt = JumpTarget;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    ins_d = ins_q;
    p4_d  = p4_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (Stall) begin
      pc_d = pc_q;
    end else if (redir) begin
      // Word-align the target; the fetched word is wrong-path.
      pc_d  = tgt & 32'hFFFF_FFFC;
      ins_d = NOP_WORD;
      p4_d  = pc_plus4;
      vld_d = 1'b0;
      cnt_d = cnt_q + 16'd1;
    end else begin
      pc_d  = pc_plus4;
      ins_d = Instruction;
      p4_d  = pc_plus4;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      ins_q <= NOP_WORD;
      p4_q  <= 32'd0;
      vld_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      pc_q  <= pc_d;
      ins_q <= ins_d;
      p4_q  <= p4_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign PC               = pc_q;
  assign IFID_Instruction = ins_q;
  assign IFID_PCPlus4     = p4_q;
  assign IFID_Valid       = vld_q;
  assign RedirectCount    = cnt_q;

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Fetch-stage PC register and IF/ID pipeline register with redirect and flush control. It takes the branch decision produced by the ID-stage equality comparator (`ORForBranch`), plus jump requests from the ID-stage control decode, and steers the program counter. On a taken redirect it squashes the wrong-path instruction in IF/ID. The hazard unit's stall freezes the PC and the IF/ID register.

## Interface
Parameters:
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset (start of the text segment).
- `NOP_WORD`, default 32'h0000_0000: instruction word injected into IF/ID on flush or reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Stall`  in  1  hazard-unit stall; freezes PC and IF/ID.
- `ORForBranch`  in  1  branch taken (BEQ/BNE resolved in ID).
- `BranchTarget`  in  32  ID-stage branch target address.
- `Jump`  in  1  J/JAL decoded in ID.
- `JumpTarget`  in  32  ID-stage jump target address.
- `JumpRegister`  in  1  JR decoded in ID.
- `JRTarget`  in  32  forwarded rs value for JR.
- `Instruction`  in  32  instruction ROM read data for the current `PC`; combinational.
- `PC`  out  32  current fetch address to the ROM.
- `IFID_Instruction`  out  32  registered instruction to ID.
- `IFID_PCPlus4`  out  32  registered PC+4 of that instruction.
- `IFID_Valid`  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- `Flush`  out  1  combinational; 1 when a redirect is accepted this cycle.
- `RedirectCount`  out  16  number of accepted redirects; wraps.

## Operation
- Reset values (`reset`=0 at a rising edge):
  - `PC`=`RESET_PC`
  - `IFID_Instruction`=`NOP_WORD`
  - `IFID_PCPlus4`=0
  - `IFID_Valid`=0
  - `RedirectCount`=0
- Reset overrides every other input. Asserting reset mid-redirect or mid-stall discards that operation.
- `PCPlus4` = `PC` + 4, computed modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Next-PC selection. The first matching row wins:
  1. `Stall`=1: hold `PC`. All redirect inputs are ignored, because ID operands are not yet valid.
  2. `JumpRegister`=1: `PC` <= {`JRTarget`[31:2], 2'b00}.
  3. `Jump`=1: `PC` <= {`JumpTarget`[31:2], 2'b00}.
  4. `ORForBranch`=1: `PC` <= {`BranchTarget`[31:2], 2'b00}.
  5. Otherwise: `PC` <= `PCPlus4`.
- Redirect accepted: `Flush` = ~`Stall` & (`JumpRegister` | `Jump` | `ORForBranch`). `Flush` is forced to 0 while `reset`=0.
- IF/ID update, in priority order:
  - `Stall`=1: hold all three IF/ID fields.
  - `Flush`=1: `IFID_Instruction` <= `NOP_WORD`, `IFID_Valid` <= 0, `IFID_PCPlus4` <= `PCPlus4`.
  - Otherwise: `IFID_Instruction` <= `Instruction`, `IFID_PCPlus4` <= `PCPlus4`, `IFID_Valid` <= 1.
- `RedirectCount` increments by 1 on every edge where `Flush`=1. It wraps from 0xFFFF to 0x0000.
- The block has no branch delay slot: the instruction fetched in the redirect cycle is always squashed.
- Effective state machine:
  - RESET goes to RUN on the first edge with `reset`=1.
  - RUN stays in RUN on PC+4 or a redirect.
  - RUN goes to HOLD while `Stall`=1.
  - HOLD returns to RUN when `Stall`=0.

## Timing
- Fetch latency: a word at address A appears on `IFID_Instruction` one edge after `PC`=A.
- Redirect penalty: exactly one bubble (`IFID_Valid`=0 for one cycle).
  - The target address is on `PC` the cycle after `Flush`=1.
  - The target instruction reaches IF/ID one cycle later.
- Stall: `PC` and IF/ID stay frozen for exactly as many cycles as `Stall`=1. No instruction is lost or duplicated.
- A redirect held off by `Stall` takes effect on the first unstalled edge, provided ID still presents it. The block keeps no memory of a stalled redirect.
- Back-to-back redirects on consecutive cycles are legal. The second one comes from a bubble, so control normally keeps it at 0. If it is asserted anyway, it is still honoured and counted.
- `Flush` is purely combinational from the inputs. It has no registered delay.

## Test plan
- Reset: hold `reset`=0 for 2 edges with random inputs. Required after the edges: `PC`=0x0040_0000, `IFID_Valid`=0, `IFID_Instruction`=0, `RedirectCount`=0. Then release reset with ROM[0x0040_0000]=0x2008_0005. Required after the next edge: `PC`=0x0040_0004, `IFID_Instruction`=0x2008_0005, `IFID_PCPlus4`=0x0040_0004, `IFID_Valid`=1.
- Taken branch: at `PC`=0x0040_0008, drive `ORForBranch`=1 and `BranchTarget`=0x0040_0040. Required: `Flush`=1 in that cycle. After the next edge: `PC`=0x0040_0040, `IFID_Valid`=0, `IFID_Instruction`=0, `RedirectCount`=1. After one more edge: `IFID_Valid`=1 with ROM[0x0040_0040] in IF/ID.
- Stall beats branch: drive `Stall`=1 and `ORForBranch`=1 for 3 cycles. Required: `PC` and IF/ID are unchanged, `Flush`=0, and the count is unchanged. Then drop `Stall` with `ORForBranch` still 1. Required: the redirect occurs on that edge.
- Priority: drive `JumpRegister`=1 (`JRTarget`=0x0040_0103), `Jump`=1 (`JumpTarget`=0x0040_0200) and `ORForBranch`=1 together. Required: `PC`=0x0040_0100 (low bits cleared, JR wins), and `RedirectCount` increments by exactly 1.
- Wrap-around:
  - Force the PC path to 0xFFFF_FFFC with no redirect. Required: next `PC`=0x0000_0000 and `IFID_PCPlus4`=0x0000_0000.
  - Apply 65 536 redirects. Required: `RedirectCount` returns to 0.
- Reset mid-redirect: assert `reset`=0 in the same cycle as `Jump`=1. Required: `PC`=`RESET_PC`, `Flush`=0, `RedirectCount` is 0 (not 1).
